// File: rtl/fp32_defs.sv
// IEEE-754 single-precision field masks and the total-order key used by the
// classifier decision stage.
package fp32_defs;

    localparam logic [31:0] FP32_EXP_MASK = 32'h7F80_0000;
    localparam logic [31:0] FP32_MAN_MASK = 32'h007F_FFFF;
    localparam int          FP32_SIGN_BIT = 31;

    // Maps fp32 bit patterns onto unsigned integers that sort in numeric order.
    function automatic logic [31:0] fp32_order_key(input logic [31:0] x);
        return x[FP32_SIGN_BIT] ? ~x : (x ^ 32'h8000_0000);
    endfunction

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return ((x & FP32_EXP_MASK) == FP32_EXP_MASK) && ((x & FP32_MAN_MASK) != 32'h0);
    endfunction

    function automatic logic fp32_is_zero(input logic [31:0] x);
        return (x & (FP32_EXP_MASK | FP32_MAN_MASK)) == 32'h0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Storage carries no reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/argmax_2class.sv
// Two-class argmax after the final FC layer: registers the logits, picks the
// winner by fp32 total order, buffers results and keeps per-class hit counts.
module argmax_2class
    import fp32_defs::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [2*DATA_WIDTH-1:0] i_data,
    input  logic                    ready_in,
    output logic                    valid_out,
    output logic                    o_class,
    output logic [DATA_WIDTH-1:0]   o_score,
    output logic                    o_nan,
    output logic                    overflow,
    output logic [CNT_WIDTH-1:0]    count0,
    output logic [CNT_WIDTH-1:0]    count1
);

    localparam int NUM_CLASSES = 2;
    localparam int ENTRY_W     = DATA_WIDTH + 2;

    genvar gi;

    logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] logit_in;
    logic [NUM_CLASSES-1:0]                 nan_in;

    logic                                   s1_valid_reg;
    logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] s1_logit_reg;
    logic [NUM_CLASSES-1:0]                 s1_nan_reg;

    logic [DATA_WIDTH-1:0] key0;
    logic [DATA_WIDTH-1:0] key1;
    logic                  win_class;
    logic [DATA_WIDTH-1:0] win_score;
    logic                  win_nan;

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               overflow_reg;

    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : gen_in
            assign logit_in[gi] = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign nan_in[gi]   = fp32_is_nan(logit_in[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_reg <= 1'b0;
            s1_logit_reg <= '0;
            s1_nan_reg   <= '0;
        end else begin
            s1_valid_reg <= valid_in;
            if (valid_in) begin
                s1_logit_reg <= logit_in;
                s1_nan_reg   <= nan_in;
            end
        end
    end

    // A lone NaN always loses; with two NaNs or a signed-zero pair class 0 keeps the win.
    always_comb begin
        key0      = fp32_order_key(s1_logit_reg[0]);
        key1      = fp32_order_key(s1_logit_reg[1]);
        win_class = 1'b0;
        if (s1_nan_reg[0] && !s1_nan_reg[1]) begin
            win_class = 1'b1;
        end else if (s1_nan_reg[1]) begin
            win_class = 1'b0;
        end else if (fp32_is_zero(s1_logit_reg[0]) && fp32_is_zero(s1_logit_reg[1])) begin
            win_class = 1'b0;
        end else begin
            win_class = (key1 > key0);
        end
        win_score = win_class ? s1_logit_reg[1] : s1_logit_reg[0];
        win_nan   = |s1_nan_reg;
    end

    assign fifo_din = {win_nan, win_class, win_score};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid_reg),
        .pop   (ready_in),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_reg <= 1'b0;
        end else if (s1_valid_reg && fifo_full && !ready_in) begin
            overflow_reg <= 1'b1;
        end
    end

    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : gen_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic                 hit;

            assign hit = s1_valid_reg && (win_class == 1'(gi));

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (hit && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    // Head fields are masked while empty so unwritten storage never shows.
    assign valid_out = !fifo_empty;
    assign o_class   = valid_out & fifo_dout[DATA_WIDTH];
    assign o_nan     = valid_out & fifo_dout[DATA_WIDTH+1];
    assign o_score   = valid_out ? fifo_dout[DATA_WIDTH-1:0] : '0;
    assign overflow  = overflow_reg;
    assign count0    = gen_cnt[0].cnt_reg;
    assign count1    = gen_cnt[1].cnt_reg;

endmodule

// File: tb/tb_argmax_2class.sv
// Randomized and directed bench for argmax_2class against a queue-based
// reference model of decisions, FIFO occupancy, drops and saturating counts.
module tb_argmax_2class;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        nan;
        logic        cls;
        logic [31:0] score;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [63:0] i_data = '0;
    logic        ready_in = 1'b0;

    logic        valid_out, o_class, o_nan, overflow;
    logic [31:0] o_score;
    logic [15:0] count0, count1;

    logic        valid_out_s, o_class_s, o_nan_s, overflow_s;
    logic [31:0] o_score_s;
    logic [1:0]  count0_s, count1_s;

    int checks = 0;
    int failures = 0;

    res_t        q[$];
    logic        s1_v = 1'b0;
    logic [31:0] s1_c0 = '0;
    logic [31:0] s1_c1 = '0;
    int          n0 = 0;
    int          n1 = 0;
    logic        ovf = 1'b0;

    logic [31:0] specials [11] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                                   32'hFF80_0000, 32'h7FC0_0000, 32'hFFC0_0001,
                                   32'h3F80_0000, 32'hBF80_0000, 32'h0000_0001,
                                   32'h8000_0001, 32'h7F7F_FFFF};

    always #5 clk = ~clk;

    argmax_2class #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .i_data(i_data), .ready_in(ready_in),
        .valid_out(valid_out), .o_class(o_class), .o_score(o_score), .o_nan(o_nan),
        .overflow(overflow), .count0(count0), .count1(count1)
    );

    argmax_2class #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .valid_in(valid_in), .i_data(i_data), .ready_in(ready_in),
        .valid_out(valid_out_s), .o_class(o_class_s), .o_score(o_score_s), .o_nan(o_nan_s),
        .overflow(overflow_s), .count0(count0_s), .count1(count1_s)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

    // Numeric a > b on sign-magnitude values, with the two zeros equal.
    function automatic logic greater(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'h0 && b[30:0] == 31'h0) return 1'b0;
        if (a[31] != b[31]) return !a[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic res_t decide(input logic [31:0] c0, input logic [31:0] c1);
        res_t r;
        logic na, nb;
        na = is_nan(c0);
        nb = is_nan(c1);
        r.nan = na | nb;
        if (na && nb)  r.cls = 1'b0;
        else if (na)   r.cls = 1'b1;
        else if (nb)   r.cls = 1'b0;
        else           r.cls = greater(c1, c0);
        r.score = r.cls ? c1 : c0;
        return r;
    endfunction

    function automatic int sat3(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    task automatic step(input logic r, input logic v, input logic [31:0] c0,
                        input logic [31:0] c1, input logic rdy);
        int   pre;
        logic popped;
        res_t nr;
        rst      = r;
        valid_in = v;
        i_data   = {c1, c0};
        ready_in = rdy;
        @(posedge clk);
        #1;
        if (!r) begin
            q.delete();
            s1_v = 1'b0;
            n0   = 0;
            n1   = 0;
            ovf  = 1'b0;
        end else begin
            pre    = q.size();
            popped = rdy && (pre > 0);
            if (popped) begin
                $display("txn class=%0d score=%h nan=%0d", q[0].cls, q[0].score, q[0].nan);
                void'(q.pop_front());
            end
            if (s1_v) begin
                nr = decide(s1_c0, s1_c1);
                if (nr.cls) n1++; else n0++;
                if (pre < DEPTH || popped) q.push_back(nr);
                else ovf = 1'b1;
            end
            s1_v  = v;
            s1_c0 = c0;
            s1_c1 = c1;
        end
        check("valid_out", 64'(valid_out), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("o_class", 64'(o_class), 64'(q[0].cls));
            check("o_score", 64'(o_score), 64'(q[0].score));
            check("o_nan",   64'(o_nan),   64'(q[0].nan));
        end else if (!r) begin
            check("rst_o_class", 64'(o_class), 64'(0));
            check("rst_o_score", 64'(o_score), 64'(0));
            check("rst_o_nan",   64'(o_nan),   64'(0));
        end
        check("overflow", 64'(overflow), 64'(ovf));
        check("count0",   64'(count0),   64'(n0));
        check("count1",   64'(count1),   64'(n1));
        check("count0_sat", 64'(count0_s), 64'(sat3(n0)));
        check("count1_sat", 64'(count1_s), 64'(sat3(n1)));
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    function automatic logic [31:0] rand_logit();
        if ($urandom_range(1, 0) == 1) return specials[$urandom_range(10, 0)];
        return $urandom;
    endfunction

    initial begin
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // 1: latency and basic win
        step(1'b1, 1'b1, 32'hBF80_0000, 32'h3F80_0000, 1'b1);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        check("t1_valid_at_t2", 64'(valid_out), 64'(1));
        check("t1_class", 64'(o_class), 64'(1));
        idle(2, 1'b1);

        // 2: signed zero tie, then negatives
        step(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b1);
        step(1'b1, 1'b1, 32'hC040_0000, 32'hC000_0000, 1'b1);
        idle(3, 1'b1);

        // 3: NaN handling
        step(1'b1, 1'b1, 32'h7FC0_0000, 32'hC000_0000, 1'b1);
        step(1'b1, 1'b1, 32'h7FC0_0000, 32'hFF80_0001, 1'b1);
        idle(3, 1'b1);

        // 4: fill while stalled, drop the fifth, then drain
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 32'h4000_0000 + 32'(i), 32'h3F00_0000 + 32'(i * 3), 1'b0);
        idle(2, 1'b0);
        check("t4_overflow", 64'(overflow), 64'(1));
        check("t4_total", 64'(count0) + 64'(count1), 64'(5));
        idle(6, 1'b1);
        check("t4_drained", 64'(valid_out), 64'(0));

        // 5: reset with entries in FIFO and in S1
        step(1'b1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        step(1'b1, 1'b1, 32'h4040_0000, 32'h4080_0000, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h40A0_0000, 32'h40C0_0000, 1'b0);
        step(1'b0, 1'b1, 32'h40E0_0000, 32'h4100_0000, 1'b0);
        check("t5_valid_out", 64'(valid_out), 64'(0));
        idle(5, 1'b1);

        // 6: saturation on the narrow-counter instance
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 32'hBF80_0000, 32'h3F80_0000 + 32'(i), 1'b1);
        idle(3, 1'b1);
        check("t6_count1_sat", 64'(count1_s), 64'(3));
        check("t6_count0", 64'(count0_s), 64'(0));

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99, 0) != 0), ($urandom_range(1, 0) == 1),
                 rand_logit(), rand_logit(), ($urandom_range(9, 0) < 6));
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
